mips_lsu: RTL
=============

MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 The block SHALL have parameters:
- ADDR_W, default 32, byte-address width (min 8).
- TIMEOUT, default 255, cycles allowed for mem_ack before abort (min 1).
REQ-002 The block SHALL have ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU access request.
- req_ready  output  1  block can accept a request.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  response strobe.
- rsp_rdata  output  32  extended load data.
- rsp_err  output  1  misaligned, illegal size or timeout.
- mem_req  output  1  memory access strobe.
- mem_we  output  1  memory write.
- mem_be  output  4  byte lane enables, bit i = bits[8i+7:8i].
- mem_addr  output  ADDR_W-2  word address, req_addr[ADDR_W-1:2].
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory completes access this cycle.
- mem_rdata  input  32  read word, valid with mem_ack.
- busy  output  1  state is not IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 In IDLE, when req_valid=1, the block SHALL latch all req_* inputs and leave IDLE on the next edge.
REQ-005 Misalignment SHALL be half with addr[0]=1, word with addr[1:0]!=0, or size=11; these requests SHALL go to RESP with rsp_err=1, rsp_rdata=0, and no mem_req.
REQ-006 Aligned requests SHALL go to ACCESS, which SHALL hold mem_req=1 with mem_we, mem_be, mem_addr and mem_wdata stable until mem_ack=1.
REQ-007 mem_be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, and 1111 for word; mem_be SHALL be 0 when mem_req=0.
REQ-008 mem_wdata SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-009 On mem_ack in ACCESS, the block SHALL register the extracted load lane and go to RESP; lanes are little-endian, byte lane addr[1:0], half lane addr[1].
REQ-010 Load result SHALL be the lane extended to 32 bits per req_unsigned; for word loads req_unsigned SHALL be ignored.
REQ-011 Stores SHALL return rsp_rdata=0 and rsp_err=0.
REQ-012 A wait counter SHALL count ACCESS cycles without ack; after TIMEOUT such cycles, the block SHALL drop mem_req and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-013 A mem_ack in the same cycle as timeout expiry SHALL win: the access completes normally.
REQ-014 RESP SHALL assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-015 Minimum latency SHALL be accept at edge N, mem_req in cycle N+1, with ack in N+1 giving rsp_valid in N+2; misaligned requests give rsp_valid in N+1.
REQ-016 mem_ack outside ACCESS SHALL be ignored.
REQ-017 rsp_rdata and rsp_err SHALL hold their value until the next response.

Reset
REQ-018 When reset=1 at an edge, the block SHALL enter IDLE, clear the wait counter, and clear rsp_valid, rsp_rdata, rsp_err, mem_req, mem_we, mem_be and busy; req_ready SHALL be 1.
REQ-019 Reset during ACCESS SHALL deassert mem_req at that edge and SHALL produce no response for the aborted access.

Structure
REQ-020 Package mips_lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum, and the lane width constant (4).
REQ-021 Load lane selection and extension SHALL be the combinational sub-module mips_lsu_align, with inputs rdata, addr[1:0], size and unsigned, and output data.
REQ-022 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide.

Verification
REQ-023 LB: addr=0x...03, signed, mem_rdata=0x80AA_BBCC, ack in the first cycle -> rsp_rdata=0xFFFF_FF80, rsp_err=0, rsp_valid 2 cycles after accept.
REQ-024 LHU: addr=0x...02, mem_rdata=0x8001_1234 -> rsp_rdata=0x0000_8001; LH at addr 0x...00 -> 0x0000_1234.
REQ-025 SB: addr=0x...01, wdata=0x0000_00A5 -> mem_be=0010, mem_wdata=0xA5A5_A5A5, mem_we=1; SW at addr 0x...02 -> rsp_err=1 with no mem_req.
REQ-026 TIMEOUT=4 with mem_ack never asserted -> mem_req high 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0; a repeat with ack on the 4th cycle -> normal response.
REQ-027 Reset asserted in the 2nd ACCESS cycle -> mem_req=0, busy=0, req_ready=1 after the edge, and no rsp_valid.
REQ-028 Back-to-back req_valid held high -> one request per 3 cycles with ack-in-first-cycle memory, and req_ready=0 in ACCESS and RESP.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// mips_lsu_pkg: size encodings, FSM state, lane width and request decode helpers
package mips_lsu_pkg;
  localparam int LANES = 4;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == SZ_HALF && a[0]) || (size == SZ_WORD && a != 2'b00) || size == 2'b11;
  endfunction
  function automatic logic [LANES-1:0] lane_be(input logic [1:0] size, input logic [1:0] a);
    return size == SZ_BYTE ? 4'b0001 << a : size == SZ_HALF ? 4'b0011 << a : 4'b1111;
  endfunction
  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] w);
    return size == SZ_BYTE ? {4{w[7:0]}} : size == SZ_HALF ? {2{w[15:0]}} : w;
  endfunction
endpackage

// File: rtl/mips_lsu_align.sv
// mips_lsu_align: little-endian load lane select and sign/zero extension
//   rdata: memory word, addr: byte offset, size: access size,
//   unsigned_ld: zero-extend when 1, data: extended result (word loads pass through)
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    data = size == SZ_BYTE ? {{24{~unsigned_ld & b[7]}}, b} :
           size == SZ_HALF ? {{16{~unsigned_ld & h[15]}}, h} : rdata;
endmodule

// File: rtl/mips_lsu.sv
// mips_lsu: MIPS load/store unit with alignment checks, lane steering and ack timeout
//   req_*: CPU request (valid/ready handshake), rsp_*: one-cycle response strobe
//   with held data/error, mem_*: word-addressed memory port held until mem_ack,
//   busy: not idle
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [LANES-1:0]  mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic we_q, uns_q, bad;
  logic [1:0] size_q, lo_q;
  logic [31:0] ld_data;
  assign bad = misaligned(req_size, req_addr[1:0]);
  mips_lsu_align u_align (
    .rdata(mem_rdata), .addr(lo_q), .size(size_q), .unsigned_ld(uns_q), .data(ld_data)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          uns_q     <= req_unsigned;
          size_q    <= req_size;
          lo_q      <= req_addr[1:0];
          mem_addr  <= req_addr[ADDR_W-1:2];
          mem_wdata <= wdata_rep(req_size, req_wdata);
          req_ready <= 1'b0;
          busy      <= 1'b1;
          cnt       <= '0;
          if (bad) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state   <= ACCESS;
            mem_req <= 1'b1;
            mem_we  <= req_we;
            mem_be  <= lane_be(req_size, req_addr[1:0]);
          end
        end
        // ack on the expiry cycle still completes the access normally
        ACCESS: if (mem_ack || cnt == CW'(TIMEOUT - 1)) begin
          state     <= RESP;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          rsp_valid <= 1'b1;
          rsp_err   <= ~mem_ack;
          rsp_rdata <= mem_ack && !we_q ? ld_data : '0;
        end else cnt <= cnt + 1'b1;
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
